// File: rtl/adma_as_tx_seq.sv
// adma_as_tx_seq: descriptor queue feeding a single-outstanding DMA transaction issuer.
// Optional completion interrupt (irq/irq_clr) is built when ADMA_TX_SEQ_IRQ_EN is defined.
module adma_as_tx_seq #(
  parameter int SRC_ADDR_W   = 32,
  parameter int DST_ADDR_W   = 32,
  parameter int DMA_LENGTH_W = 16,
  parameter int DESC_DEPTH   = 4,
  parameter int DONE_CNT_W   = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [SRC_ADDR_W-1:0]          desc_src_addr,
  input  logic [DST_ADDR_W-1:0]          desc_dst_addr,
  input  logic [DMA_LENGTH_W-1:0]        desc_len,
  input  logic                           desc_wr,
  output logic                           desc_full,
  output logic [$clog2(DESC_DEPTH):0]    q_level,
  output logic [SRC_ADDR_W-1:0]          tx_src_addr,
  output logic [DST_ADDR_W-1:0]          tx_dst_addr,
  output logic [DMA_LENGTH_W-1:0]        tx_len,
  output logic                           tx_vld,
  input  logic                           tx_rdy,
  input  logic                           tx_done,
  output logic                           busy,
  output logic [DONE_CNT_W-1:0]          done_cnt
`ifdef ADMA_TX_SEQ_IRQ_EN
  ,
  input  logic                           irq_clr,
  output logic                           irq
`endif
);
  localparam int AW = $clog2(DESC_DEPTH);
  localparam int LW = AW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t                  state_q;
  logic [SRC_ADDR_W-1:0]   src_mem [DESC_DEPTH];
  logic [DST_ADDR_W-1:0]   dst_mem [DESC_DEPTH];
  logic [DMA_LENGTH_W-1:0] len_mem [DESC_DEPTH];
  logic [AW-1:0]           wptr_q, rptr_q;
  logic [LW-1:0]           level_q, level_d;
  logic [DONE_CNT_W-1:0]   done_cnt_q;
  logic                    tx_vld_q;
  logic                    push, pop, skip, handshake, done_ev;
  logic [DMA_LENGTH_W-1:0] head_len;
  // A write while full is dropped even if the head pops this cycle.
  always_comb begin
    desc_full = level_q == LW'(DESC_DEPTH);
    push      = desc_wr && !desc_full;
    head_len  = len_mem[rptr_q];
    skip      = state_q == IDLE && level_q != '0 && head_len == '0;
    handshake = state_q == ISSUE && tx_rdy;
    pop       = skip || handshake;
    done_ev   = skip || (state_q == WAIT && tx_done);
    level_d   = level_q + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clk) begin
    if (push) begin
      src_mem[wptr_q] <= desc_src_addr;
      dst_mem[wptr_q] <= desc_dst_addr;
      len_mem[wptr_q] <= desc_len;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= push ? wptr_q + AW'(1) : wptr_q;
      rptr_q  <= pop ? rptr_q + AW'(1) : rptr_q;
      level_q <= level_d;
    end
  end
  // Zero-length heads retire directly from IDLE without ever being issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_vld_q   <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      done_cnt_q <= done_ev ? done_cnt_q + DONE_CNT_W'(1) : done_cnt_q;
      case (state_q)
        IDLE: begin
          if (level_q != '0 && head_len != '0) begin
            state_q  <= ISSUE;
            tx_vld_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (tx_rdy) begin
            state_q  <= WAIT;
            tx_vld_q <= 1'b0;
          end
        end
        WAIT: begin
          if (tx_done) state_q <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          tx_vld_q <= 1'b0;
        end
      endcase
    end
  end
`ifdef ADMA_TX_SEQ_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else irq_q <= (done_ev && level_d == '0) ? 1'b1 : irq_clr ? 1'b0 : irq_q;
  end
  assign irq = irq_q;
`endif
  assign q_level     = level_q;
  assign tx_vld      = tx_vld_q;
  assign tx_src_addr = src_mem[rptr_q];
  assign tx_dst_addr = dst_mem[rptr_q];
  assign tx_len      = head_len;
  assign busy        = state_q != IDLE || level_q != '0;
  assign done_cnt    = done_cnt_q;
endmodule

// File: tb/tb_adma_as_tx_seq.sv
// tb_adma_as_tx_seq: directed self-checking bench for adma_as_tx_seq (default parameters).
module tb_adma_as_tx_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] desc_src_addr = '0;
  logic [31:0] desc_dst_addr = '0;
  logic [15:0] desc_len = '0;
  logic        desc_wr = 1'b0;
  logic        desc_full;
  logic [2:0]  q_level;
  logic [31:0] tx_src_addr, tx_dst_addr;
  logic [15:0] tx_len;
  logic        tx_vld;
  logic        tx_rdy = 1'b0;
  logic        tx_done = 1'b0;
  logic        busy;
  logic [15:0] done_cnt;
`ifdef ADMA_TX_SEQ_IRQ_EN
  logic        irq_clr = 1'b0;
  logic        irq;
`endif
  int errors = 0;
  int checks = 0;

  adma_as_tx_seq dut (
    .clk(clk), .rst_n(rst_n),
    .desc_src_addr(desc_src_addr), .desc_dst_addr(desc_dst_addr),
    .desc_len(desc_len), .desc_wr(desc_wr), .desc_full(desc_full),
    .q_level(q_level), .tx_src_addr(tx_src_addr), .tx_dst_addr(tx_dst_addr),
    .tx_len(tx_len), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .tx_done(tx_done),
    .busy(busy), .done_cnt(done_cnt)
`ifdef ADMA_TX_SEQ_IRQ_EN
    , .irq_clr(irq_clr), .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step;
    step;
    checks++; if (tx_vld !== 1'b0) begin errors++; $display("FAIL reset_tx_vld got=%0h exp=0", tx_vld); end
    checks++; if (q_level !== 3'd0) begin errors++; $display("FAIL reset_q_level got=%0d exp=0", q_level); end
    checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL reset_done_cnt got=%0d exp=0", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", busy); end
    checks++; if (desc_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0h exp=0", desc_full); end
`ifdef ADMA_TX_SEQ_IRQ_EN
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%0h exp=0", irq); end
`endif
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_single;
    desc_src_addr = 32'h1000; desc_dst_addr = 32'h2000; desc_len = 16'd64;
    desc_wr = 1'b1; tx_rdy = 1'b1;
    step;
    desc_wr = 1'b0;
    checks++; if (tx_vld !== 1'b0) begin errors++; $display("FAIL single_vld_n1 got=%0h exp=0", tx_vld); end
    checks++; if (q_level !== 3'd1) begin errors++; $display("FAIL single_level got=%0d exp=1", q_level); end
    step;
    checks++; if (tx_vld !== 1'b1) begin errors++; $display("FAIL single_vld_n2 got=%0h exp=1", tx_vld); end
    checks++; if (tx_src_addr !== 32'h1000) begin errors++; $display("FAIL single_src got=%0h exp=1000", tx_src_addr); end
    checks++; if (tx_dst_addr !== 32'h2000) begin errors++; $display("FAIL single_dst got=%0h exp=2000", tx_dst_addr); end
    checks++; if (tx_len !== 16'd64) begin errors++; $display("FAIL single_len got=%0d exp=64", tx_len); end
    step;
    tx_rdy = 1'b0;
    checks++; if (tx_vld !== 1'b0) begin errors++; $display("FAIL single_wait_vld got=%0h exp=0", tx_vld); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_wait_busy got=%0h exp=1", busy); end
    checks++; if (q_level !== 3'd0) begin errors++; $display("FAIL single_wait_level got=%0d exp=0", q_level); end
    tx_done = 1'b1;
    step;
    tx_done = 1'b0;
    checks++; if (done_cnt !== 16'd1) begin errors++; $display("FAIL single_done_cnt got=%0d exp=1", done_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy got=%0h exp=0", busy); end
  endtask

  function automatic logic [31:0] exp_src(int i); return 32'h3000 + 32'(i * 16); endfunction
  function automatic logic [31:0] exp_dst(int i); return 32'h4000 + 32'(i * 16); endfunction
  function automatic logic [15:0] exp_len(int i); return 16'((i + 1) * 4); endfunction

  task automatic test_full;
    for (int i = 0; i < 5; i++) begin
      desc_src_addr = exp_src(i); desc_dst_addr = exp_dst(i); desc_len = exp_len(i);
      desc_wr = 1'b1;
      step;
      if (i == 3) begin
        checks++; if (desc_full !== 1'b1) begin errors++; $display("FAIL full_after4 got=%0h exp=1", desc_full); end
      end
    end
    desc_wr = 1'b0;
    checks++; if (q_level !== 3'd4) begin errors++; $display("FAIL full_level got=%0d exp=4", q_level); end
    checks++; if (desc_full !== 1'b1) begin errors++; $display("FAIL full_flag got=%0h exp=1", desc_full); end
  endtask

  task automatic test_hold;
    for (int c = 0; c < 10; c++) begin
      checks++; if (tx_vld !== 1'b1) begin errors++; $display("FAIL hold_vld c=%0d got=%0h exp=1", c, tx_vld); end
      checks++; if (tx_src_addr !== exp_src(0) || tx_dst_addr !== exp_dst(0) || tx_len !== exp_len(0)) begin
        errors++; $display("FAIL hold_data c=%0d got=%0h/%0h/%0d exp=%0h/%0h/%0d", c, tx_src_addr, tx_dst_addr, tx_len, exp_src(0), exp_dst(0), exp_len(0));
      end
      checks++; if (q_level !== 3'd4) begin errors++; $display("FAIL hold_level c=%0d got=%0d exp=4", c, q_level); end
      step;
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      for (int n = 0; n < 10 && tx_vld !== 1'b1; n++) step;
      checks++; if (tx_vld !== 1'b1) begin errors++; $display("FAIL drain_vld i=%0d got=%0h exp=1", i, tx_vld); end
      checks++; if (tx_src_addr !== exp_src(i) || tx_dst_addr !== exp_dst(i) || tx_len !== exp_len(i)) begin
        errors++; $display("FAIL drain_data i=%0d got=%0h/%0h/%0d exp=%0h/%0h/%0d", i, tx_src_addr, tx_dst_addr, tx_len, exp_src(i), exp_dst(i), exp_len(i));
      end
      tx_rdy = 1'b1;
      step;
      tx_rdy = 1'b0;
      tx_done = 1'b1;
      step;
      tx_done = 1'b0;
    end
    step;
    checks++; if (tx_vld !== 1'b0) begin errors++; $display("FAIL drain_idle_vld got=%0h exp=0", tx_vld); end
    checks++; if (q_level !== 3'd0) begin errors++; $display("FAIL drain_level got=%0d exp=0", q_level); end
    checks++; if (done_cnt !== 16'd5) begin errors++; $display("FAIL drain_done_cnt got=%0d exp=5", done_cnt); end
    checks++; if (busy !== 1'b0 || desc_full !== 1'b0) begin errors++; $display("FAIL drain_flags got=%0h%0h exp=00", busy, desc_full); end
  endtask

  task automatic test_zero_len;
    tx_done = 1'b1;
    step;
    tx_done = 1'b0;
    checks++; if (done_cnt !== 16'd5) begin errors++; $display("FAIL stray_done got=%0d exp=5", done_cnt); end
    desc_src_addr = 32'hAAAA; desc_dst_addr = 32'hBBBB; desc_len = 16'd0; desc_wr = 1'b1;
    step;
    checks++; if (tx_vld !== 1'b0) begin errors++; $display("FAIL zero_vld1 got=%0h exp=0", tx_vld); end
    desc_src_addr = 32'h5000; desc_dst_addr = 32'h6000; desc_len = 16'd8;
    step;
    desc_wr = 1'b0;
    checks++; if (tx_vld !== 1'b0) begin errors++; $display("FAIL zero_vld2 got=%0h exp=0", tx_vld); end
    checks++; if (done_cnt !== 16'd6) begin errors++; $display("FAIL zero_skip_cnt got=%0d exp=6", done_cnt); end
    checks++; if (q_level !== 3'd1) begin errors++; $display("FAIL zero_level got=%0d exp=1", q_level); end
    step;
    checks++; if (tx_vld !== 1'b1 || tx_len !== 16'd8 || tx_src_addr !== 32'h5000 || tx_dst_addr !== 32'h6000) begin
      errors++; $display("FAIL zero_issue got=%0h %0h/%0h/%0d exp=1 5000/6000/8", tx_vld, tx_src_addr, tx_dst_addr, tx_len);
    end
    tx_rdy = 1'b1;
    step;
    tx_rdy = 1'b0;
    tx_done = 1'b1;
    step;
    tx_done = 1'b0;
    checks++; if (done_cnt !== 16'd7) begin errors++; $display("FAIL zero_done_cnt got=%0d exp=7", done_cnt); end
`ifdef ADMA_TX_SEQ_IRQ_EN
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL zero_irq got=%0h exp=1", irq); end
`endif
  endtask

  task automatic test_reset_mid;
    desc_src_addr = 32'h7000; desc_dst_addr = 32'h8000; desc_len = 16'd4; desc_wr = 1'b1;
    step;
    desc_src_addr = 32'h7100; desc_dst_addr = 32'h8100; desc_len = 16'd12;
    tx_rdy = 1'b1;
    step;
    desc_wr = 1'b0;
    step;
    tx_rdy = 1'b0;
    checks++; if (busy !== 1'b1 || tx_vld !== 1'b0 || q_level !== 3'd1) begin
      errors++; $display("FAIL mid_wait got=busy%0h vld%0h lvl%0d exp=busy1 vld0 lvl1", busy, tx_vld, q_level);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (q_level !== 3'd0 || done_cnt !== 16'd0 || busy !== 1'b0 || tx_vld !== 1'b0) begin
      errors++; $display("FAIL mid_reset got=lvl%0d cnt%0d busy%0h vld%0h exp=0 0 0 0", q_level, done_cnt, busy, tx_vld);
    end
`ifdef ADMA_TX_SEQ_IRQ_EN
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_reset_irq got=%0h exp=0", irq); end
`endif
    step;
    step;
    rst_n = 1'b1;
    step;
    tx_done = 1'b1;
    step;
    tx_done = 1'b0;
    step;
    checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL post_reset_cnt got=%0d exp=0", done_cnt); end
    checks++; if (q_level !== 3'd0 || busy !== 1'b0 || tx_vld !== 1'b0) begin
      errors++; $display("FAIL post_reset_state got=lvl%0d busy%0h vld%0h exp=0 0 0", q_level, busy, tx_vld);
    end
    desc_len = 16'd0; desc_wr = 1'b1;
    step;
    desc_wr = 1'b0;
    step;
    checks++; if (done_cnt !== 16'd1 || q_level !== 3'd0) begin
      errors++; $display("FAIL final_skip got=cnt%0d lvl%0d exp=cnt1 lvl0", done_cnt, q_level);
    end
`ifdef ADMA_TX_SEQ_IRQ_EN
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL final_irq got=%0h exp=1", irq); end
    irq_clr = 1'b1;
    step;
    irq_clr = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clr got=%0h exp=0", irq); end
`endif
  endtask

  initial begin
    test_reset;
    test_single;
    test_full;
    test_hold;
    test_back_to_back;
    test_zero_len;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
